// File: rtl/dphy_tx_pkg.sv
// Shared types and default framing bytes for the D-PHY transmit packet scheduler.
package dphy_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DTYPE   = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    typedef enum logic {
        OWN_CMD = 1'b0,
        OWN_PIX = 1'b1
    } owner_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;
    localparam logic [7:0] CMD_DT_DEF    = 8'h39;
    localparam logic [7:0] PIX_DT_DEF    = 8'h3E;
    localparam logic [7:0] FILL_BYTE_DEF = 8'h00;

    function automatic logic [7:0] dtype_of(input owner_e own, input logic [7:0] cmd_dt,
                                            input logic [7:0] pix_dt);
        return (own == OWN_CMD) ? cmd_dt : pix_dt;
    endfunction

endpackage

// File: rtl/dphy_tx_rr_arb.sv
// Two-way round-robin arbiter: combinational winner/load, registered one-cycle grant strobes.
module dphy_tx_rr_arb
    import dphy_tx_pkg::*;
(
    input  logic   wclk,
    input  logic   reset,
    input  logic   arb_en,
    input  logic   cmd_req,
    input  logic   pix_req,
    output logic   load,
    output owner_e win_owner,
    output logic   cmd_gnt,
    output logic   pix_gnt
);

    owner_e last_owner_r;
    logic   cmd_gnt_r;
    logic   pix_gnt_r;

    // winner selection; on a tie the requester that did not go last wins
    always_comb begin
        load      = arb_en && (cmd_req || pix_req);
        win_owner = OWN_PIX;
        if (cmd_req && pix_req) begin
            win_owner = (last_owner_r == OWN_PIX) ? OWN_CMD : OWN_PIX;
        end else if (cmd_req) begin
            win_owner = OWN_CMD;
        end else begin
            win_owner = OWN_PIX;
        end
    end

    // grant strobes and round-robin history
    always_ff @(posedge wclk) begin
        if (reset) begin
            last_owner_r <= OWN_PIX;
            cmd_gnt_r    <= 1'b0;
            pix_gnt_r    <= 1'b0;
        end else begin
            cmd_gnt_r <= load && (win_owner == OWN_CMD);
            pix_gnt_r <= load && (win_owner == OWN_PIX);
            if (load) begin
                last_owner_r <= win_owner;
            end else begin
                last_owner_r <= last_owner_r;
            end
        end
    end

    assign cmd_gnt = cmd_gnt_r;
    assign pix_gnt = pix_gnt_r;

endmodule

// File: rtl/dphy_tx_sched.sv
// Packet scheduler feeding the 8-to-2 D-PHY gearbox: arbitration, SYNC/DT framing,
// byte pacing and inter-packet gap, all in the gearbox write-clock domain.
module dphy_tx_sched
    import dphy_tx_pkg::*;
#(
    parameter int unsigned PACE      = 1,
    parameter int unsigned GAP_CYC   = 8,
    parameter int unsigned LEN_W     = 12,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [7:0]  CMD_DT    = CMD_DT_DEF,
    parameter logic [7:0]  PIX_DT    = PIX_DT_DEF,
    parameter logic [7:0]  FILL_BYTE = FILL_BYTE_DEF
) (
    input  logic             wclk,
    input  logic             reset,
    input  logic             en,
    input  logic             cmd_req,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_gnt,
    output logic             cmd_pop,
    input  logic             pix_req,
    input  logic [LEN_W-1:0] pix_len,
    input  logic [7:0]       pix_data,
    input  logic             pix_valid,
    output logic             pix_gnt,
    output logic             pix_pop,
    output logic [7:0]       tx_data,
    output logic             tx_wen,
    output logic             busy,
    output logic             pkt_done,
    output logic             underrun,
    input  logic             clr_underrun
);

    localparam logic [3:0]       PACE_RELOAD = 4'(PACE - 1);
    localparam logic [7:0]       GAP_INIT    = 8'(GAP_CYC);
    localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO    = {LEN_W{1'b0}};

    state_e           state_r, next_state_s;
    owner_e           owner_r, win_owner_s;
    logic             arb_en_s, arb_load_s;
    logic [3:0]       pace_r;
    logic [7:0]       gap_r;
    logic [LEN_W-1:0] remain_r, win_len_s;
    logic [7:0]       tx_data_r, byte_s, own_data_s;
    logic             tx_wen_r, pkt_done_r, underrun_r;
    logic             emit_s, done_s, set_ur_s, slot_s, in_bytes_s, own_valid_s, remain_dec_s;

    assign arb_en_s = (state_r == ST_IDLE) && en;

    dphy_tx_rr_arb u_arb (
        .wclk      (wclk),
        .reset     (reset),
        .arb_en    (arb_en_s),
        .cmd_req   (cmd_req),
        .pix_req   (pix_req),
        .load      (arb_load_s),
        .win_owner (win_owner_s),
        .cmd_gnt   (cmd_gnt),
        .pix_gnt   (pix_gnt)
    );

    // next-state, byte slot selection and payload pop
    always_comb begin
        next_state_s = state_r;
        emit_s       = 1'b0;
        byte_s       = tx_data_r;
        done_s       = 1'b0;
        set_ur_s     = 1'b0;
        remain_dec_s = 1'b0;
        cmd_pop      = 1'b0;
        pix_pop      = 1'b0;
        in_bytes_s   = (state_r == ST_SYNC) || (state_r == ST_DTYPE) || (state_r == ST_PAYLOAD);
        slot_s       = in_bytes_s && (pace_r == 4'd0);
        own_valid_s  = (owner_r == OWN_CMD) ? cmd_valid : pix_valid;
        own_data_s   = (owner_r == OWN_CMD) ? cmd_data : pix_data;
        win_len_s    = (win_owner_s == OWN_CMD) ? cmd_len : pix_len;
        case (state_r)
            ST_IDLE: begin
                if (arb_load_s) next_state_s = ST_SYNC;
                else            next_state_s = ST_IDLE;
            end
            ST_SYNC: begin
                if (slot_s) begin
                    emit_s       = 1'b1;
                    byte_s       = SYNC_BYTE;
                    next_state_s = ST_DTYPE;
                end else begin
                    next_state_s = ST_SYNC;
                end
            end
            ST_DTYPE: begin
                if (slot_s) begin
                    emit_s = 1'b1;
                    byte_s = dtype_of(owner_r, CMD_DT, PIX_DT);
                    if (remain_r == LEN_ZERO) begin
                        done_s       = 1'b1;
                        next_state_s = ST_GAP;
                    end else begin
                        next_state_s = ST_PAYLOAD;
                    end
                end else begin
                    next_state_s = ST_DTYPE;
                end
            end
            ST_PAYLOAD: begin
                if (slot_s) begin
                    emit_s       = 1'b1;
                    remain_dec_s = 1'b1;
                    if (own_valid_s) begin
                        byte_s  = own_data_s;
                        cmd_pop = (owner_r == OWN_CMD);
                        pix_pop = (owner_r == OWN_PIX);
                    end else begin
                        byte_s   = FILL_BYTE;
                        set_ur_s = 1'b1;
                    end
                    // exit test before the decrement keeps remain from wrapping
                    if (remain_r == LEN_ONE) begin
                        done_s       = 1'b1;
                        next_state_s = ST_GAP;
                    end else begin
                        next_state_s = ST_PAYLOAD;
                    end
                end else begin
                    next_state_s = ST_PAYLOAD;
                end
            end
            ST_GAP: begin
                if (gap_r == 8'd1) next_state_s = ST_IDLE;
                else               next_state_s = ST_GAP;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge wclk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // pacing, gap, length and ownership registers
    always_ff @(posedge wclk) begin
        if (reset) begin
            pace_r   <= 4'd0;
            gap_r    <= 8'd0;
            remain_r <= LEN_ZERO;
            owner_r  <= OWN_CMD;
        end else begin
            if (arb_load_s)    pace_r <= 4'd0;
            else if (slot_s)   pace_r <= PACE_RELOAD;
            else if (in_bytes_s) pace_r <= pace_r - 4'd1;
            else               pace_r <= 4'd0;

            if ((next_state_s == ST_GAP) && (state_r != ST_GAP)) gap_r <= GAP_INIT;
            else if (state_r == ST_GAP)                          gap_r <= gap_r - 8'd1;
            else                                                 gap_r <= gap_r;

            if (arb_load_s)        remain_r <= win_len_s;
            else if (remain_dec_s) remain_r <= remain_r - LEN_ONE;
            else                   remain_r <= remain_r;

            if (arb_load_s) owner_r <= win_owner_s;
            else            owner_r <= owner_r;
        end
    end

    // registered gearbox write port, packet-done strobe and sticky underrun
    always_ff @(posedge wclk) begin
        if (reset) begin
            tx_data_r  <= 8'h00;
            tx_wen_r   <= 1'b0;
            pkt_done_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            tx_wen_r   <= emit_s;
            pkt_done_r <= done_s;
            if (emit_s) tx_data_r <= byte_s;
            else        tx_data_r <= tx_data_r;
            if (set_ur_s)          underrun_r <= 1'b1;
            else if (clr_underrun) underrun_r <= 1'b0;
            else                   underrun_r <= underrun_r;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_wen   = tx_wen_r;
    assign pkt_done = pkt_done_r;
    assign underrun = underrun_r;
    assign busy     = (state_r != ST_IDLE);

endmodule
